// File: rtl/loop_nest_issuer_pkg.sv
// Shared definitions for the loop-nest issuer: FSM states and default index width.
package loop_nest_issuer_pkg;

    localparam int unsigned DEFAULT_IDX_W = 16;

    typedef enum logic [1:0] {
        LN_IDLE = 2'd0,
        LN_RUN  = 2'd1,
        LN_FIN  = 2'd2
    } ln_state_t;

endpackage

// File: rtl/loop_nest_issuer_counter.sv
// Odometer of N_DIMS ripple-carry wrap counters; dim 0 is innermost.
module nested_index_counter
    import loop_nest_issuer_pkg::*;
#(
    parameter int unsigned N_DIMS = 2,
    parameter int unsigned IDX_W  = DEFAULT_IDX_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    en,
    input  logic [N_DIMS*IDX_W-1:0] trips,
    output logic [N_DIMS*IDX_W-1:0] idx,
    output logic                    all_last
);

    localparam logic [IDX_W-1:0] ONE = IDX_W'(1);

    logic [IDX_W-1:0]  cnt [N_DIMS];
    logic [N_DIMS-1:0] at_last;
    logic [N_DIMS-1:0] carry;

    // Per-dim final-value detect, carry ripple and flattened index export.
    always_comb begin
        at_last  = '0;
        carry    = '0;
        idx      = '0;
        for (int unsigned d = 0; d < N_DIMS; d++) begin
            at_last[d]              = (cnt[d] == (trips[d*IDX_W +: IDX_W] - ONE));
            idx[d*IDX_W +: IDX_W]   = cnt[d];
        end
        carry[0] = en;
        for (int unsigned d = 1; d < N_DIMS; d++) begin
            carry[d] = carry[d-1] & at_last[d-1];
        end
        all_last = &at_last;
    end

    // Each dim wraps to 0 at trip-1 and otherwise increments when its carry-in is set.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            for (int unsigned d = 0; d < N_DIMS; d++) begin
                cnt[d] <= '0;
            end
        end else begin
            for (int unsigned d = 0; d < N_DIMS; d++) begin
                if (carry[d]) begin
                    cnt[d] <= at_last[d] ? '0 : cnt[d] + ONE;
                end
            end
        end
    end

endmodule

// File: rtl/loop_nest_issuer.sv
// Loop-nest issuer: latches trip counts at start, issues one iteration every II
// unstalled cycles and exports the per-dimension index vector with each issue.
module loop_nest_issuer
    import loop_nest_issuer_pkg::*;
#(
    parameter int unsigned N_DIMS = 2,
    parameter int unsigned IDX_W  = DEFAULT_IDX_W,
    parameter int unsigned II     = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [N_DIMS*IDX_W-1:0] trip_counts,
    input  logic                    stall,
    output logic                    issue,
    output logic [N_DIMS*IDX_W-1:0] idx,
    output logic                    last,
    output logic                    busy,
    output logic                    done
);

    localparam int unsigned CD_W = (II > 1) ? $clog2(II) : 1;

    ln_state_t                 state;
    ln_state_t                 state_next;
    logic [N_DIMS*IDX_W-1:0]   trips_q;
    logic                      accept;
    logic                      any_zero;
    logic                      cd_zero;
    logic                      all_last;

    // Start acceptance and zero-trip detection on the incoming trip counts.
    always_comb begin
        accept   = (state == LN_IDLE) && start;
        any_zero = 1'b0;
        for (int unsigned d = 0; d < N_DIMS; d++) begin
            if (trip_counts[d*IDX_W +: IDX_W] == '0) begin
                any_zero = 1'b1;
            end
        end
    end

    // Next-state and output decode; issue is combinational only through stall.
    always_comb begin
        state_next = state;
        issue      = 1'b0;
        last       = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            LN_IDLE: begin
                if (start) begin
                    state_next = any_zero ? LN_FIN : LN_RUN;
                end
            end
            LN_RUN: begin
                busy  = 1'b1;
                issue = cd_zero && !stall;
                last  = issue && all_last;
                if (last) begin
                    state_next = LN_FIN;
                end
            end
            LN_FIN: begin
                done       = 1'b1;
                state_next = LN_IDLE;
            end
            default: state_next = LN_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LN_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Trip counts are captured only on an accepted start.
    always_ff @(posedge clk) begin
        if (rst) begin
            trips_q <= '0;
        end else if (accept) begin
            trips_q <= trip_counts;
        end
    end

    // II countdown exists only when II>1; with II=1 every unstalled RUN cycle issues.
    if (II > 1) begin : g_cd
        logic [CD_W-1:0] cd;

        // Reload on issue, tick down on unstalled idle RUN cycles, hold under stall.
        always_ff @(posedge clk) begin
            if (rst || accept) begin
                cd <= '0;
            end else if (issue) begin
                cd <= CD_W'(II - 1);
            end else if ((state == LN_RUN) && (cd != '0) && !stall) begin
                cd <= cd - CD_W'(1);
            end
        end

        assign cd_zero = (cd == '0);
    end else begin : g_no_cd
        assign cd_zero = 1'b1;
    end

    nested_index_counter #(
        .N_DIMS (N_DIMS),
        .IDX_W  (IDX_W)
    ) u_counter (
        .clk      (clk),
        .rst      (rst),
        .clear    (accept),
        .en       (issue),
        .trips    (trips_q),
        .idx      (idx),
        .all_last (all_last)
    );

endmodule

// File: tb/tb_loop_nest_issuer.sv
// Bench for loop_nest_issuer: an II=1 and an II=3 instance (N_DIMS=2, IDX_W=8).
module tb_loop_nest_issuer;

    localparam int MAXC = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_s [2];
    logic [15:0] trips_s [2];
    logic        stall_s [2];
    logic        issue_s [2];
    logic [15:0] idx_s   [2];
    logic        last_s  [2];
    logic        busy_s  [2];
    logic        done_s  [2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        loop_nest_issuer #(
            .N_DIMS (2),
            .IDX_W  (8),
            .II     ((g == 0) ? 1 : 3)
        ) dut (
            .clk         (clk),
            .rst         (rst),
            .start       (start_s[g]),
            .trip_counts (trips_s[g]),
            .stall       (stall_s[g]),
            .issue       (issue_s[g]),
            .idx         (idx_s[g]),
            .last        (last_s[g]),
            .busy        (busy_s[g]),
            .done        (done_s[g])
        );
    end

    typedef struct {
        bit          is_done;
        int          cyc;
        logic [15:0] idx;
        bit          last;
    } item_t;

    item_t exp_q [2][$];
    int    busy_lo [2];
    int    busy_hi [2];
    int    cyc      = 0;
    int    checks   = 0;
    int    failures = 0;
    bit    mon_en   = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int d, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s dut%0d cyc=%0d actual=%0h required=%0h", name, d, cyc, act, req);
        end
    endtask

    // Event monitor: pops expected issues/done pulses as the DUTs present them.
    item_t it;
    always @(negedge clk) begin
        if (mon_en) begin
            for (int d = 0; d < 2; d++) begin
                while (exp_q[d].size() > 0 && exp_q[d][0].cyc < cyc) begin
                    it = exp_q[d].pop_front();
                    check(it.is_done ? "missed_done" : "missed_issue", d, 32'(it.cyc), 32'(cyc));
                end
                check("busy", d, 32'(busy_s[d]), 32'(cyc >= busy_lo[d] && cyc <= busy_hi[d]));
                check("last_implies_issue", d, 32'(last_s[d] & ~issue_s[d]), 32'd0);
                if (issue_s[d]) begin
                    if (exp_q[d].size() == 0) begin
                        check("unexpected_issue", d, 32'(issue_s[d]), 32'd0);
                    end else begin
                        it = exp_q[d].pop_front();
                        check("issue_kind", d, 32'(it.is_done), 32'd0);
                        check("issue_cycle", d, 32'(cyc), 32'(it.cyc));
                        check("idx", d, 32'(idx_s[d]), 32'(it.idx));
                        check("last", d, 32'(last_s[d]), 32'(it.last));
                    end
                end else if (busy_s[d] && exp_q[d].size() > 0 && !exp_q[d][0].is_done) begin
                    check("pending_idx", d, 32'(idx_s[d]), 32'(exp_q[d][0].idx));
                end
                if (done_s[d]) begin
                    if (exp_q[d].size() == 0) begin
                        check("unexpected_done", d, 32'(done_s[d]), 32'd0);
                    end else begin
                        it = exp_q[d].pop_front();
                        check("done_kind", d, 32'(it.is_done), 32'd1);
                        check("done_cycle", d, 32'(cyc), 32'(it.cyc));
                    end
                end
            end
        end
    end

    // One nest on DUT d. Called at #1 after a rising edge; that cycle is cycle 0.
    // stall_mode: 0 none, 1 random, 2 cycles 2-3. junk_mode: 0 none, 1 random
    // starts while busy, 2 start with trips 7,7 at cycle 3. abort_rel>0: rst there.
    task automatic run_nest(input int d, input int t1, input int t0,
                            input int stall_mode, input int junk_mode, input int abort_rel);
        bit    st [MAXC];
        int    ii;
        int    base;
        int    n;
        int    t;
        int    k;
        int    last_t;
        int    done_rel;
        int    end_rel;
        item_t e;
        ii = (d == 0) ? 1 : 3;
        for (int c = 0; c < MAXC; c++) begin
            st[c] = (stall_mode == 1) ? ($urandom_range(3) == 0)
                  : (stall_mode == 2) ? (c == 2 || c == 3) : 1'b0;
        end
        base   = cyc;
        n      = t1 * t0;
        last_t = 0;
        t      = 1;
        for (int i = 0; i < n; i++) begin
            while (st[t] && t < MAXC - 1) t++;
            e.is_done = 1'b0;
            e.cyc     = base + t;
            e.idx     = {8'(i / t0), 8'(i % t0)};
            e.last    = (i == n - 1);
            last_t    = t;
            if (abort_rel == 0 || t <= abort_rel) exp_q[d].push_back(e);
            k = 0;
            t++;
            while (k < ii - 1 && t < MAXC - 1) begin
                if (!st[t]) k++;
                t++;
            end
        end
        done_rel = (n == 0) ? 1 : last_t + 1;
        if (abort_rel == 0) begin
            e.is_done = 1'b1;
            e.cyc     = base + done_rel;
            e.idx     = '0;
            e.last    = 1'b0;
            exp_q[d].push_back(e);
        end
        busy_lo[d] = base + 1;
        busy_hi[d] = (n == 0) ? base : base + ((abort_rel > 0 && abort_rel < last_t) ? abort_rel : last_t);
        end_rel    = (abort_rel > 0) ? abort_rel : done_rel;
        for (int c = 0; c <= end_rel; c++) begin
            if (c > 0) begin
                @(posedge clk);
                #1;
            end
            start_s[d] = (c == 0) || (junk_mode == 1 && $urandom_range(9) == 0) || (junk_mode == 2 && c == 3);
            trips_s[d] = (c == 0) ? {8'(t1), 8'(t0)} : ((junk_mode == 2) ? 16'h0707 : 16'($urandom));
            stall_s[d] = (c == 0) ? 1'b0 : st[c];
            rst        = (abort_rel > 0 && c == abort_rel);
        end
        @(posedge clk);
        #1;
        start_s[d] = 1'b0;
        stall_s[d] = 1'b0;
        rst        = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            start_s[d] = 1'b0;
            trips_s[d] = '0;
            stall_s[d] = 1'b0;
            busy_lo[d] = 1;
            busy_hi[d] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            check("reset_issue", d, 32'(issue_s[d]), 32'd0);
            check("reset_idx", d, 32'(idx_s[d]), 32'd0);
            check("reset_last", d, 32'(last_s[d]), 32'd0);
            check("reset_busy", d, 32'(busy_s[d]), 32'd0);
            check("reset_done", d, 32'(done_s[d]), 32'd0);
        end
        rst    = 1'b0;
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        // Directed nests from the block's reference scenarios.
        run_nest(0, 3, 2, 0, 2, 0);   // trips (3,2), ignored start with 7,7 at cycle 3
        run_nest(1, 1, 4, 0, 0, 0);   // II=3
        run_nest(0, 1, 4, 2, 0, 0);   // stall in cycles 2-3
        run_nest(0, 0, 5, 0, 0, 0);   // zero trip, immediate restart follows
        run_nest(0, 3, 2, 0, 0, 3);   // rst at cycle 3
        check("abort_idx", 0, 32'(idx_s[0]), 32'd0);
        check("abort_issue", 0, 32'(issue_s[0]), 32'd0);
        check("abort_done", 0, 32'(done_s[0]), 32'd0);
        @(posedge clk);
        #1;
        run_nest(0, 3, 2, 0, 0, 0);   // restart after abort

        // start together with rst: must stay idle.
        rst        = 1'b1;
        start_s[0] = 1'b1;
        trips_s[0] = 16'h0303;
        @(posedge clk);
        #1;
        rst        = 1'b0;
        start_s[0] = 1'b0;
        check("start_with_rst_busy", 0, 32'(busy_s[0]), 32'd0);
        repeat (2) @(posedge clk);
        #1;

        // Randomized nests on both instances.
        for (int r = 0; r < 60; r++) begin
            run_nest(r % 2, $urandom_range(4), $urandom_range(4), 1, 1, 0);
        end

        repeat (5) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            check("drained", d, 32'(exp_q[d].size()), 32'd0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
